// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe_if
//  Description : Instruction-in / immediate-out handshake bundle for
//                imm_gen_pipe. "slave" is the generator, "master" the user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [2:0]      in_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_src, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_src, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Decode-stage immediate generator (I/S/B/J/U/Z) with optional
//                opcode auto-decode, buffered through a small output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int AUTO_DECODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    imm_gen_pipe_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    localparam logic [2:0] c_T_I = 3'b000;
    localparam logic [2:0] c_T_S = 3'b001;
    localparam logic [2:0] c_T_B = 3'b010;
    localparam logic [2:0] c_T_J = 3'b011;
    localparam logic [2:0] c_T_U = 3'b100;
    localparam logic [2:0] c_T_Z = 3'b101;
    localparam logic [2:0] c_T_N = 3'b110;
    localparam logic [2:0] c_T_R = 3'b111;

    logic [31:0]     w_instr;
    logic [2:0]      w_type;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;

    assign w_instr = bus.in_instr;

    generate
        if (AUTO_DECODE != 0) begin : g_auto_decode
            logic [6:0] w_opcode;
            logic       w_src_unused;

            assign w_opcode     = w_instr[6:0];
            assign w_src_unused = ^bus.in_src;

            always_comb begin
                case (w_opcode)
                    7'b0000011, 7'b0010011, 7'b1100111: w_type = c_T_I;
                    7'b0100011:                         w_type = c_T_S;
                    7'b1100011:                         w_type = c_T_B;
                    7'b1101111:                         w_type = c_T_J;
                    7'b0110111, 7'b0010111:             w_type = c_T_U;
                    // funct3[2] separates the immediate CSR forms from the register ones
                    7'b1110011:  w_type = w_instr[14] ? c_T_Z : c_T_I;
                    7'b0110011, 7'b0001111:             w_type = c_T_N;
                    7'b0011011:  w_type = (XLEN == 64) ? c_T_I : c_T_R;
                    default:                            w_type = c_T_R;
                endcase
            end
        end else begin : g_src_decode
            assign w_type = bus.in_src;
        end
    endgenerate

    // Every format fits in 32 bits; widening to XLEN is a plain sign extension.
    always_comb begin
        w_imm32 = '0;
        case (w_type)
            c_T_I: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            c_T_S: w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            c_T_B: w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                              w_instr[30:25], w_instr[11:8], 1'b0};
            c_T_J: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                              w_instr[20], w_instr[30:21], 1'b0};
            c_T_U: w_imm32 = {w_instr[31:12], 12'b0};
            c_T_Z: w_imm32 = {27'b0, w_instr[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_narrow
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_illegal = (w_type == c_T_R);

    logic [XLEN-1:0] r_imm     [DEPTH];
    logic [2:0]      r_type    [DEPTH];
    logic            r_illegal [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;

    // Ready comes only from the registered count, so out_ready never reaches in_ready.
    assign bus.in_ready = (r_count != c_FULL);
    assign w_out_valid  = (r_count != '0);
    assign w_push       = bus.in_valid && (r_count != c_FULL) && !flush;
    assign w_pop        = w_out_valid && bus.out_ready && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm[r_wptr]     <= w_imm;
            r_type[r_wptr]    <= w_type;
            r_illegal[r_wptr] <= w_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_valid   = w_out_valid;
    assign bus.out_imm     = w_out_valid ? r_imm[r_rptr]     : '0;
    assign bus.out_type    = w_out_valid ? r_type[r_rptr]    : c_T_N;
    assign bus.out_illegal = w_out_valid ? r_illegal[r_rptr] : 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Scoreboard bench driving three imm_gen_pipe configurations
//                (auto/32, auto/64, explicit-src/32) in lock step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;
    localparam logic [2:0] c_I = 3'b000, c_S = 3'b001, c_B = 3'b010, c_J = 3'b011;
    localparam logic [2:0] c_U = 3'b100, c_Z = 3'b101, c_N = 3'b110, c_R = 3'b111;
    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        bit          en;
        bit          lat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q_a[$], q_b[$], q_c[$];
    exp_t e_a, e_b, e_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_gen_pipe_if #(.XLEN(32)) bus_a ();
    imm_gen_pipe_if #(.XLEN(64)) bus_b ();
    imm_gen_pipe_if #(.XLEN(32)) bus_c ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_a));
    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .AUTO_DECODE(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_b));
    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(0)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t ex(input logic [63:0] imm, input logic [2:0] typ,
                                input logic ill, input bit lat);
        exp_t e;
        e.imm = imm; e.typ = typ; e.ill = ill; e.en = 1'b1; e.lat = lat; e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t nx();
        exp_t e;
        e.imm = '0; e.typ = '0; e.ill = 1'b0; e.en = 1'b0; e.lat = 1'b0; e.cyc = 0;
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] instr, input logic [2:0] src);
        bus_a.in_valid = v; bus_a.in_instr = instr; bus_a.in_src = src;
        bus_b.in_valid = v; bus_b.in_instr = instr; bus_b.in_src = src;
        bus_c.in_valid = v; bus_c.in_instr = instr; bus_c.in_src = src;
    endtask

    task automatic set_ready(input logic r);
        bus_a.out_ready = r; bus_b.out_ready = r; bus_c.out_ready = r;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one instruction to all three DUTs; expectations are queued on the handshake.
    task automatic send(input logic [31:0] instr, input logic [2:0] src,
                        input exp_t ea, input exp_t eb, input exp_t ec);
        set_in(1'b1, instr, src);
        for (int n = 0; n <= 50; n++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                ea.cyc = cyc; eb.cyc = cyc; ec.cyc = cyc;
                q_a.push_back(ea); q_b.push_back(eb); q_c.push_back(ec);
                tick(1);
                return;
            end
            tick(1);
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && !flush && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) chk("a_spurious", 64'(bus_a.out_imm), 64'hDEAD);
            else begin
                e_a = q_a.pop_front();
                if (e_a.en) begin
                    chk("a_imm", 64'(bus_a.out_imm), e_a.imm);
                    chk("a_type", 64'(bus_a.out_type), 64'(e_a.typ));
                    chk("a_illegal", 64'(bus_a.out_illegal), 64'(e_a.ill));
                    if (e_a.lat) chk("a_latency", 64'(cyc), 64'(e_a.cyc + 1));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && !flush && bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) chk("b_spurious", bus_b.out_imm, 64'hDEAD);
            else begin
                e_b = q_b.pop_front();
                if (e_b.en) begin
                    chk("b_imm", bus_b.out_imm, e_b.imm);
                    chk("b_type", 64'(bus_b.out_type), 64'(e_b.typ));
                    chk("b_illegal", 64'(bus_b.out_illegal), 64'(e_b.ill));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && !flush && bus_c.out_valid && bus_c.out_ready) begin
            if (q_c.size() == 0) chk("c_spurious", 64'(bus_c.out_imm), 64'hDEAD);
            else begin
                e_c = q_c.pop_front();
                if (e_c.en) begin
                    chk("c_imm", 64'(bus_c.out_imm), e_c.imm);
                    chk("c_type", 64'(bus_c.out_type), 64'(e_c.typ));
                    chk("c_illegal", 64'(bus_c.out_illegal), 64'(e_c.ill));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 32'h0, 3'b000);
        set_ready(1'b1);
        tick(3);
        chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_ready", 64'(bus_a.in_ready), 64'd1);
        chk("rst_imm", 64'(bus_a.out_imm), 64'd0);
        chk("rst_type", 64'(bus_a.out_type), 64'(c_N));
        chk("rst_illegal", 64'(bus_a.out_illegal), 64'd0);
        reset = 1'b0;
        tick(1);

        // Back-to-back stream, out_ready high: one result per cycle, latency one.
        send(32'hFFF00093, c_I, ex(32'hFFFFFFFF, c_I, 0, 1), ex(c_ONES, c_I, 0, 0), ex(32'hFFFFFFFF, c_I, 0, 0));
        send(32'h0020A423, c_S, ex(32'h8, c_S, 0, 1), ex(64'h8, c_S, 0, 0), ex(32'h8, c_S, 0, 0));
        send(32'hFE000EE3, c_B, ex(32'hFFFFFFFC, c_B, 0, 1), ex(64'hFFFFFFFF_FFFFFFFC, c_B, 0, 0), ex(32'hFFFFFFFC, c_B, 0, 0));
        send(32'h123452B7, c_U, ex(32'h12345000, c_U, 0, 1), ex(64'h12345000, c_U, 0, 0), ex(32'h12345000, c_U, 0, 0));
        send(32'h3402D073, c_Z, ex(32'h5, c_Z, 0, 1), ex(64'h5, c_Z, 0, 0), ex(32'h5, c_Z, 0, 0));
        send(32'h34029073, c_I, ex(32'h340, c_I, 0, 1), ex(64'h340, c_I, 0, 0), ex(32'h340, c_I, 0, 0));
        send(32'h800002B7, c_U, ex(32'h80000000, c_U, 0, 1), ex(64'hFFFFFFFF_80000000, c_U, 0, 0), ex(32'h80000000, c_U, 0, 0));
        send(32'hFFF0009B, c_I, ex(32'h0, c_R, 1, 1), ex(c_ONES, c_I, 0, 0), ex(32'hFFFFFFFF, c_I, 0, 0));
        send(32'hFFF00093, c_R, ex(32'hFFFFFFFF, c_I, 0, 1), ex(c_ONES, c_I, 0, 0), ex(32'h0, c_R, 1, 0));
        send(32'hFFF00093, c_N, ex(32'hFFFFFFFF, c_I, 0, 1), ex(c_ONES, c_I, 0, 0), ex(32'h0, c_N, 0, 0));
        send(32'h0040006F, c_J, ex(32'h4, c_J, 0, 1), ex(64'h4, c_J, 0, 0), ex(32'h4, c_J, 0, 0));
        send(32'h00000033, c_N, ex(32'h0, c_N, 0, 1), ex(64'h0, c_N, 0, 0), ex(32'h0, c_N, 0, 0));
        send(32'h0000007F, c_N, ex(32'h0, c_R, 1, 1), ex(64'h0, c_R, 1, 0), ex(32'h0, c_N, 0, 0));
        set_in(1'b0, 32'h0, 3'b000);
        tick(3);
        chk("stream_drain_a", 64'(q_a.size()), 64'd0);
        chk("stream_drain_b", 64'(q_b.size()), 64'd0);
        chk("stream_drain_c", 64'(q_c.size()), 64'd0);

        // Backpressure: A and B fill the FIFO, C must wait until A leaves.
        set_ready(1'b0);
        send(32'hFFF00093, c_I, ex(32'hFFFFFFFF, c_I, 0, 0), nx(), nx());
        send(32'h0020A423, c_S, ex(32'h8, c_S, 0, 0), nx(), nx());
        set_in(1'b1, 32'h123452B7, c_U);
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 64'(bus_a.in_ready), 64'd0);
            chk("stall_valid", 64'(bus_a.out_valid), 64'd1);
            chk("stall_imm", 64'(bus_a.out_imm), 64'hFFFFFFFF);
            chk("stall_type", 64'(bus_a.out_type), 64'(c_I));
        end
        tick(1);
        set_ready(1'b1);
        send(32'h123452B7, c_U, ex(32'h12345000, c_U, 0, 0), nx(), nx());
        set_in(1'b0, 32'h0, 3'b000);
        tick(4);
        chk("bp_drain_a", 64'(q_a.size()), 64'd0);

        // Flush with two entries held and a valid input on the flush cycle.
        set_ready(1'b0);
        send(32'h0020A423, c_S, nx(), nx(), nx());
        send(32'hFE000EE3, c_B, nx(), nx(), nx());
        set_in(1'b1, 32'h0040006F, c_J);
        flush = 1'b1;
        q_a.delete(); q_b.delete(); q_c.delete();
        tick(1);
        flush = 1'b0;
        set_in(1'b0, 32'h0, 3'b000);
        @(negedge clk);
        chk("flush_valid", 64'(bus_a.out_valid), 64'd0);
        chk("flush_ready", 64'(bus_a.in_ready), 64'd1);
        chk("flush_type", 64'(bus_a.out_type), 64'(c_N));
        tick(1);
        set_ready(1'b1);
        tick(3);

        // Asynchronous reset between edges with one entry queued.
        set_ready(1'b0);
        send(32'h0020A423, c_S, nx(), nx(), nx());
        set_in(1'b0, 32'h0, 3'b000);
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus_a.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("arst_imm", 64'(bus_a.out_imm), 64'd0);
        chk("arst_type", 64'(bus_a.out_type), 64'(c_N));
        chk("arst_ready", 64'(bus_a.in_ready), 64'd1);
        q_a.delete(); q_b.delete(); q_c.delete();
        tick(2);
        chk("rst_hold_ready", 64'(bus_a.in_ready), 64'd1);
        #2 reset = 1'b0;
        tick(1);
        chk("post_rst_valid", 64'(bus_a.out_valid), 64'd0);
        set_ready(1'b1);
        send(32'hFFF00093, c_I, ex(32'hFFFFFFFF, c_I, 0, 1), ex(c_ONES, c_I, 0, 0), ex(32'hFFFFFFFF, c_I, 0, 0));
        set_in(1'b0, 32'h0, 3'b000);
        tick(4);
        chk("final_drain_a", 64'(q_a.size()), 64'd0);
        chk("final_drain_b", 64'(q_b.size()), 64'd0);
        chk("final_drain_c", 64'(q_c.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction per cycle over a valid/ready handshake. It extracts and sign- or zero-extends the immediate for all RV32/RV64 base formats: I, S, B, J, U, and the CSR zimm. An optional opcode-driven auto-decode mode removes the need for an external immSrc. Results are queued in a small output FIFO so the downstream execute stage can apply backpressure without a combinational ready path.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- AUTO_DECODE, 0: 0 = type taken from in_src; 1 = type derived from opcode, in_src ignored.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; empties the FIFO and drops this cycle's input.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; equals !full.
- in_instr  in  32  instruction word.
- in_src  in  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 N (no immediate), 111 reserved.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  resolved type code, same encoding as in_src.
- out_illegal  out  1  type unresolvable.

## Operation
- Extension rules. Sign bit is instr[31], replicated to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - Z: instr[19:15] zero-extended.
  - N: imm 0, illegal 0.
  - 111: imm 0, illegal 1.
- AUTO_DECODE=1 opcode map:
  - 0000011, 0010011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 1110011 → Z if instr[14]=1, else I.
  - 0110011, 0001111 → N.
  - 0011011 → I when XLEN=64, else illegal.
  - Any other opcode → type 111, illegal 1.
- Push occurs when in_valid && in_ready && !flush; the computed {imm, type, illegal} is written at the tail.
- Pop occurs when out_valid && out_ready && !flush; the head advances.
- FIFO state:
  - Read and write pointers wrap modulo DEPTH.
  - Occupancy counter runs 0..DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- in_ready depends only on registered occupancy. There is no combinational path from out_ready.
- When full, a same-cycle pop does not enable a push.
- When out_valid=0: out_imm=0, out_type=110, out_illegal=0.
- flush has priority over push and pop. On the next cycle: count=0, pointers=0, out_valid=0.
- Reset, asserted at any time including mid-transfer:
  - Immediately clears count and pointers.
  - out_valid=0, out_imm=0, out_type=110, out_illegal=0.
  - in_ready=1 while held and after release.
  - FIFO contents are discarded.

## Timing
- Latency: a push at edge N makes out_valid=1 and shows the entry from edge N, visible in the cycle after N.
- Throughput: one per cycle with out_ready held high.
- Full: in_ready=0 from the cycle after the DEPTH-th unpopped push, until the cycle after the first pop.
- Empty: out_valid=0; an out_ready assertion has no effect.
- Stability: out_imm, out_type and out_illegal hold steady while out_valid=1 and out_ready=0.
- Ordering: strict FIFO order.

## Test plan
- **Basic formats**, AUTO_DECODE=1, XLEN=32, out_ready=1, back-to-back pushes:
  - 0xFFF00093 → imm 0xFFFFFFFF, type I.
  - 0x0020A423 → 0x00000008, type S.
  - 0xFE000EE3 → 0xFFFFFFFC, type B.
  - 0x123452B7 → 0x12345000, type U.
  - 0x3402D073 → 0x00000005, type Z.
  - Each result appears exactly one cycle after its push.
- **XLEN=64**:
  - 0x800002B7 → 0xFFFFFFFF80000000.
  - 0xFFF0009B (opcode 0011011) → 0xFFFFFFFFFFFFFFFF, illegal 0.
  - The same opcode with XLEN=32 → illegal 1, imm 0.
- **Explicit source**, AUTO_DECODE=0:
  - in_src=111 → illegal 1, imm 0.
  - in_src=110 → imm 0, illegal 0.
  - in_src=011 with 0x0040006F (jal +4) → imm 0x00000004.
- **Backpressure**, DEPTH=2, out_ready=0, three consecutive pushes A, B, C:
  - in_ready=0 after B; C is held.
  - Raise out_ready: outputs A, B, C in order, no loss or duplication.
  - Outputs hold stable while stalled.
- **Flush**: FIFO holds 2 entries, in_valid=1, flush=1 for one cycle → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- **Reset**: assert reset asynchronously between edges with 1 entry queued → out_valid drops immediately, out_imm=0. After release, a single push produces a single output.
